// File: rtl/cp0_exception_ctrl_if.sv
// cp0_exception_ctrl_if
//   Bundles the MEM-stage exception inputs, the mfc0/mtc0 register port and the
//   flush/redirect outputs of cp0_exception_ctrl.
//   master : the pipeline side (drives exception info and CP0 accesses)
//   slave  : the CP0 controller
interface cp0_exception_ctrl_if;
  logic [31:0] except_type;
  logic [31:0] except_pc;
  logic        is_in_delayslot;
  logic [31:0] bad_addr;
  logic [5:0]  hw_int;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [4:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        flush;
  logic        stall_req;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        timer_int;

  modport master (
    output except_type, except_pc, is_in_delayslot, bad_addr, hw_int,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, cp0_status, cp0_cause, cp0_epc, flush, stall_req,
           new_pc, new_pc_valid, timer_int
  );

  modport slave (
    input  except_type, except_pc, is_in_delayslot, bad_addr, hw_int,
           cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, cp0_status, cp0_cause, cp0_epc, flush, stall_req,
           new_pc, new_pc_valid, timer_int
  );
endinterface

// File: rtl/cp0_exception_ctrl.sv
// cp0_exception_ctrl
//   Exception commit sequencer and CP0 register file for the 5-stage MIPS core.
//   A committed exception/ERET runs RUN -> FLUSH (FLUSH_CYCLES) -> REDIRECT -> RUN,
//   then presents the handler vector (or EPC for ERET) on new_pc for one cycle.
//   Ports: clk, rst (async, active high), bus (cp0_exception_ctrl_if.slave):
//     exception in: except_type, except_pc, is_in_delayslot, bad_addr, hw_int
//     mtc0/mfc0   : cp0_we, cp0_waddr, cp0_wdata, cp0_raddr -> cp0_rdata
//     state out   : cp0_status, cp0_cause, cp0_epc, timer_int
//     control out : flush, stall_req, new_pc, new_pc_valid
//   Build option: CP0_TIMER_EN enables Count/Compare and timer_int.
module cp0_exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int          FLUSH_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst,
  cp0_exception_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_REDIRECT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q;
  logic [31:0] status_q, cause_q, epc_q, badvaddr_q;
  logic [31:0] count_v, compare_v, cause_v;
  logic        timer_v;
  logic        code_ok, commit, is_eret;
  logic        flush_c, stall_c, nv_c;

  always_comb begin
    code_ok = 1'b0;
    case (bus.except_type)
      32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc, 32'he: code_ok = 1'b1;
      default: code_ok = 1'b0;
    endcase
  end

  // Exceptions arriving while sequencing are ignored; upstream is already flushed.
  assign commit  = (state_q == S_RUN) && code_ok;
  assign is_eret = (bus.except_type == 32'he);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush_c = 1'b0;
    stall_c = 1'b0;
    nv_c    = 1'b0;
    case (state_q)
      S_RUN: if (commit) begin
        state_d = S_FLUSH;
        cnt_d   = 4'(FLUSH_CYCLES - 1);
      end
      S_FLUSH: begin
        flush_c = 1'b1;
        stall_c = 1'b1;
        if (cnt_q == 4'd0) state_d = S_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_REDIRECT: begin
        nv_c    = 1'b1;
        stall_c = 1'b1;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      cnt_q      <= 4'd0;
      target_q   <= 32'd0;
      status_q   <= 32'h0040_0000;
      cause_q    <= 32'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cause_q[15:10] <= bus.hw_int;
      if (commit) begin
        // Exception update wins; a same-cycle mtc0 is dropped entirely.
        if (is_eret) begin
          status_q[1] <= 1'b0;
          target_q    <= epc_q;
        end else begin
          epc_q       <= bus.is_in_delayslot ? bus.except_pc - 32'd4 : bus.except_pc;
          cause_q[31] <= bus.is_in_delayslot;
          cause_q[6:2] <= (bus.except_type == 32'h1) ? 5'd0 : bus.except_type[4:0];
          status_q[1] <= 1'b1;
          if (bus.except_type == 32'h4 || bus.except_type == 32'h5)
            badvaddr_q <= bus.bad_addr;
          target_q    <= EXC_VECTOR;
        end
      end else if (bus.cp0_we) begin
        case (bus.cp0_waddr)
          5'd12: begin
            status_q[15:8] <= bus.cp0_wdata[15:8];
            status_q[1:0]  <= bus.cp0_wdata[1:0];
          end
          5'd13:   cause_q[9:8] <= bus.cp0_wdata[9:8];
          5'd14:   epc_q        <= bus.cp0_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic        tick_q, timer_q;
  logic [31:0] count_q, compare_q;
  logic        wr_count, wr_compare;

  assign wr_count   = bus.cp0_we && !commit && (bus.cp0_waddr == 5'd9);
  assign wr_compare = bus.cp0_we && !commit && (bus.cp0_waddr == 5'd11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q    <= 1'b0;
      timer_q   <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
    end else begin
      tick_q <= ~tick_q;
      if (wr_count)    count_q <= bus.cp0_wdata;
      else if (tick_q) count_q <= count_q + 32'd1;
      if (wr_compare) begin
        compare_q <= bus.cp0_wdata;
        timer_q   <= 1'b0;
      end else if (tick_q && !wr_count && (count_q + 32'd1 == compare_q)) begin
        timer_q <= 1'b1;
      end
    end
  end

  assign count_v   = count_q;
  assign compare_v = compare_q;
  assign timer_v   = timer_q;
`else
  assign count_v   = 32'd0;
  assign compare_v = 32'd0;
  assign timer_v   = 1'b0;
`endif

  // IP7 also reflects the timer so the upstream gating sees it without extra lag.
  assign cause_v = {cause_q[31:16], cause_q[15] | timer_v, cause_q[14:0]};

  always_comb begin
    case (bus.cp0_raddr)
      5'd8:    bus.cp0_rdata = badvaddr_q;
      5'd9:    bus.cp0_rdata = count_v;
      5'd11:   bus.cp0_rdata = compare_v;
      5'd12:   bus.cp0_rdata = status_q;
      5'd13:   bus.cp0_rdata = cause_v;
      5'd14:   bus.cp0_rdata = epc_q;
      default: bus.cp0_rdata = 32'd0;
    endcase
  end

  assign bus.cp0_status   = status_q;
  assign bus.cp0_cause    = cause_v;
  assign bus.cp0_epc      = epc_q;
  assign bus.flush        = flush_c;
  assign bus.stall_req    = stall_c;
  assign bus.new_pc       = target_q;
  assign bus.new_pc_valid = nv_c;
  assign bus.timer_int    = timer_v;
endmodule

// File: tb/tb_cp0_exception_ctrl.sv
module tb_cp0_exception_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cp0_exception_ctrl_if bus ();
  cp0_exception_ctrl_if bus3 ();

  cp0_exception_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  cp0_exception_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus.except_type = 0; bus.except_pc = 0; bus.is_in_delayslot = 0; bus.bad_addr = 0;
    bus.hw_int = 0; bus.cp0_we = 0; bus.cp0_waddr = 0; bus.cp0_wdata = 0; bus.cp0_raddr = 0;
    bus3.except_type = 0; bus3.except_pc = 0; bus3.is_in_delayslot = 0; bus3.bad_addr = 0;
    bus3.hw_int = 0; bus3.cp0_we = 0; bus3.cp0_waddr = 0; bus3.cp0_wdata = 0; bus3.cp0_raddr = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    step();
    rst = 1'b1; #2; rst = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we = 1; bus.cp0_waddr = a; bus.cp0_wdata = d;
    step();
    bus.cp0_we = 0;
  endtask

  // Advances until new_pc_valid is seen (bounded); reports latency and flush cycles.
  task automatic wait_redirect(input int sel, output bit got, output logic [31:0] pc,
                               output int lat, output int nflush);
    got = 0; pc = 0; lat = 0; nflush = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      lat++;
      if ((sel == 0) ? bus.flush : bus3.flush) nflush++;
      if ((sel == 0) ? bus.new_pc_valid : bus3.new_pc_valid) begin
        got = 1;
        pc = (sel == 0) ? bus.new_pc : bus3.new_pc;
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    step(); step();
    rst = 1'b0;
    bus.cp0_raddr = 5'd8;
    #1;
    checks++; if (bus.cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL reset_status got %h exp 00400000", bus.cp0_status); end
    checks++; if (bus.cp0_cause !== 32'h0) begin errors++; $display("FAIL reset_cause got %h exp 0", bus.cp0_cause); end
    checks++; if (bus.cp0_epc !== 32'h0) begin errors++; $display("FAIL reset_epc got %h exp 0", bus.cp0_epc); end
    checks++; if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL reset_badvaddr got %h exp 0", bus.cp0_rdata); end
    checks++; if ({bus.flush, bus.stall_req, bus.new_pc_valid} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {bus.flush, bus.stall_req, bus.new_pc_valid}); end
    checks++; if (bus.new_pc !== 32'h0) begin errors++; $display("FAIL reset_newpc got %h exp 0", bus.new_pc); end
  endtask

  task automatic test_mtc0_mfc0();
    mtc0(5'd12, 32'hFFFF_FFFF);
    checks++; if (bus.cp0_status !== 32'h0040_FF03) begin errors++; $display("FAIL mtc0_status got %h exp 0040ff03", bus.cp0_status); end
    mtc0(5'd13, 32'hFFFF_FFFF);
    checks++; if (bus.cp0_cause !== 32'h0000_0300) begin errors++; $display("FAIL mtc0_cause got %h exp 00000300", bus.cp0_cause); end
    mtc0(5'd8, 32'h1234_5678);
    bus.cp0_raddr = 5'd8; #1;
    checks++; if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL badvaddr_ro got %h exp 0", bus.cp0_rdata); end
    mtc0(5'd14, 32'hCAFE_0004);
    bus.cp0_raddr = 5'd14; #1;
    checks++; if (bus.cp0_rdata !== 32'hCAFE_0004) begin errors++; $display("FAIL mfc0_epc got %h exp cafe0004", bus.cp0_rdata); end
    bus.cp0_raddr = 5'd3; #1;
    checks++; if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL mfc0_unmapped got %h exp 0", bus.cp0_rdata); end
    // hw_int is sampled with one cycle of lag
    bus.hw_int = 6'h2A; #1;
    checks++; if (bus.cp0_cause !== 32'h0000_0300) begin errors++; $display("FAIL hwint_lag got %h exp 00000300", bus.cp0_cause); end
    step();
    checks++; if (bus.cp0_cause !== 32'h0000_AB00) begin errors++; $display("FAIL hwint_ip got %h exp 0000ab00", bus.cp0_cause); end
    bus.hw_int = 0;
    do_reset();
  endtask

  task automatic test_syscall();
    bit got; logic [31:0] pc; int lat, nf;
    bus.except_type = 32'h8; bus.except_pc = 32'hBFC0_0100; bus.is_in_delayslot = 0;
    exp_q.push_back(32'hBFC0_0380);
    wait_redirect(0, got, pc, lat, nf);
    bus.except_type = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL sys_redirect got timeout exp new_pc_valid"); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (pc !== e) begin errors++; $display("FAIL sys_newpc got %h exp %h", pc, e); end
    end
    checks++; if (lat !== 2 || nf !== 1) begin errors++; $display("FAIL sys_latency got lat %0d flush %0d exp lat 2 flush 1", lat, nf); end
    checks++; if (bus.cp0_epc !== 32'hBFC0_0100) begin errors++; $display("FAIL sys_epc got %h exp bfc00100", bus.cp0_epc); end
    checks++; if (bus.cp0_cause !== 32'h0000_0020) begin errors++; $display("FAIL sys_cause got %h exp 00000020", bus.cp0_cause); end
    checks++; if (bus.cp0_status !== 32'h0040_0002) begin errors++; $display("FAIL sys_status got %h exp 00400002", bus.cp0_status); end
    step();
    checks++; if ({bus.stall_req, bus.new_pc_valid} !== 2'b00) begin errors++; $display("FAIL sys_back_to_run got %b exp 00", {bus.stall_req, bus.new_pc_valid}); end
  endtask

  task automatic test_adel_dslot();
    bit got; logic [31:0] pc; int lat, nf;
    bus.except_type = 32'h4; bus.except_pc = 32'h8000_0010; bus.is_in_delayslot = 1; bus.bad_addr = 32'h1;
    exp_q.push_back(32'hBFC0_0380);
    wait_redirect(0, got, pc, lat, nf);
    idle_inputs();
    checks++;
    if (!got) begin errors++; $display("FAIL adel_redirect got timeout exp new_pc_valid"); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (pc !== e) begin errors++; $display("FAIL adel_newpc got %h exp %h", pc, e); end
    end
    checks++; if (bus.cp0_epc !== 32'h8000_000C) begin errors++; $display("FAIL adel_epc got %h exp 8000000c", bus.cp0_epc); end
    checks++; if (bus.cp0_cause !== 32'h8000_0010) begin errors++; $display("FAIL adel_cause got %h exp 80000010", bus.cp0_cause); end
    bus.cp0_raddr = 5'd8; #1;
    checks++; if (bus.cp0_rdata !== 32'h1) begin errors++; $display("FAIL adel_badvaddr got %h exp 1", bus.cp0_rdata); end
    step();
  endtask

  task automatic test_eret();
    bit got; logic [31:0] pc; int lat, nf;
    mtc0(5'd14, 32'h8000_0040);
    bus.except_type = 32'he;
    exp_q.push_back(32'h8000_0040);
    wait_redirect(0, got, pc, lat, nf);
    bus.except_type = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL eret_redirect got timeout exp new_pc_valid"); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (pc !== e) begin errors++; $display("FAIL eret_newpc got %h exp %h", pc, e); end
    end
    checks++; if (bus.cp0_status !== 32'h0040_0000) begin errors++; $display("FAIL eret_status got %h exp 00400000", bus.cp0_status); end
    checks++; if (bus.cp0_epc !== 32'h8000_0040) begin errors++; $display("FAIL eret_epc got %h exp 80000040", bus.cp0_epc); end
    checks++; if (bus.cp0_cause !== 32'h8000_0010) begin errors++; $display("FAIL eret_cause got %h exp 80000010", bus.cp0_cause); end
    step();
  endtask

  task automatic test_back_to_back();
    bit got; logic [31:0] pc; int lat, nf;
    bus.except_type = 32'hc; bus.except_pc = 32'h8000_1000; bus.is_in_delayslot = 0;
    bus.cp0_we = 1; bus.cp0_waddr = 5'd14; bus.cp0_wdata = 32'hDEAD_BEEF;
    exp_q.push_back(32'hBFC0_0380);
    step();
    // A second exception held during FLUSH must be ignored.
    bus.cp0_we = 0; bus.except_type = 32'h8; bus.except_pc = 32'h8000_2222;
    wait_redirect(0, got, pc, lat, nf);
    idle_inputs();
    checks++;
    if (!got) begin errors++; $display("FAIL b2b_redirect got timeout exp new_pc_valid"); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (pc !== e) begin errors++; $display("FAIL b2b_newpc got %h exp %h", pc, e); end
    end
    checks++; if (bus.cp0_epc !== 32'h8000_1000) begin errors++; $display("FAIL b2b_epc got %h exp 80001000", bus.cp0_epc); end
    checks++; if (bus.cp0_cause !== 32'h0000_0030) begin errors++; $display("FAIL b2b_cause got %h exp 00000030", bus.cp0_cause); end
    step();
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL b2b_ignored got stall %b exp 0", bus.stall_req); end
  endtask

  task automatic test_int_code();
    bit got; logic [31:0] pc; int lat, nf;
    bus.except_type = 32'h1; bus.except_pc = 32'h8000_2000;
    exp_q.push_back(32'hBFC0_0380);
    wait_redirect(0, got, pc, lat, nf);
    idle_inputs();
    checks++;
    if (!got) begin errors++; $display("FAIL int_redirect got timeout exp new_pc_valid"); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (pc !== e) begin errors++; $display("FAIL int_newpc got %h exp %h", pc, e); end
    end
    checks++; if (bus.cp0_cause !== 32'h0) begin errors++; $display("FAIL int_cause got %h exp 0", bus.cp0_cause); end
    // An unlisted nonzero code must not start a sequence.
    bus.except_type = 32'h3;
    step(); step();
    checks++; if (bus.stall_req !== 1'b0) begin errors++; $display("FAIL ignored_code got stall %b exp 0", bus.stall_req); end
    idle_inputs();
  endtask

  task automatic test_timer();
    do_reset();
`ifdef CP0_TIMER_EN
    mtc0(5'd11, 32'd4);
    for (int i = 0; i < 6; i++) step();
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL timer_early got %b exp 0", bus.timer_int); end
    step();
    checks++; if (bus.timer_int !== 1'b1) begin errors++; $display("FAIL timer_rise got %b exp 1", bus.timer_int); end
    checks++; if (bus.cp0_cause[15] !== 1'b1) begin errors++; $display("FAIL timer_ip7 got %b exp 1", bus.cp0_cause[15]); end
    mtc0(5'd11, 32'd100);
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL timer_clear got %b exp 0", bus.timer_int); end
`else
    mtc0(5'd11, 32'd4);
    mtc0(5'd9, 32'd7);
    for (int i = 0; i < 10; i++) step();
    bus.cp0_raddr = 5'd9; #1;
    checks++; if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL count_off got %h exp 0", bus.cp0_rdata); end
    bus.cp0_raddr = 5'd11; #1;
    checks++; if (bus.cp0_rdata !== 32'h0) begin errors++; $display("FAIL compare_off got %h exp 0", bus.cp0_rdata); end
    checks++; if (bus.timer_int !== 1'b0) begin errors++; $display("FAIL timer_off got %b exp 0", bus.timer_int); end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid_flush();
    bit got; logic [31:0] pc; int lat, nf;
    bit seen;
    bus3.except_type = 32'h9; bus3.except_pc = 32'h8000_3000;
    exp_q.push_back(32'hBFC0_0380);
    wait_redirect(1, got, pc, lat, nf);
    bus3.except_type = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL fc3_redirect got timeout exp new_pc_valid"); end
    else begin
      logic [31:0] e = exp_q.pop_front();
      if (pc !== e) begin errors++; $display("FAIL fc3_newpc got %h exp %h", pc, e); end
    end
    checks++; if (lat !== 4 || nf !== 3) begin errors++; $display("FAIL fc3_latency got lat %0d flush %0d exp lat 4 flush 3", lat, nf); end
    checks++; if (bus3.cp0_cause !== 32'h0000_0024) begin errors++; $display("FAIL fc3_cause got %h exp 00000024", bus3.cp0_cause); end
    step();
    bus3.except_type = 32'h8; bus3.except_pc = 32'h8000_4000;
    step();
    bus3.except_type = 0;
    step();
    checks++; if (bus3.flush !== 1'b1) begin errors++; $display("FAIL rstflush_pre got %b exp 1", bus3.flush); end
    rst = 1'b1; #1;
    checks++; if ({bus3.flush, bus3.stall_req, bus3.new_pc_valid} !== 3'b000) begin errors++; $display("FAIL rstflush_ctrl got %b exp 000", {bus3.flush, bus3.stall_req, bus3.new_pc_valid}); end
    checks++; if (bus3.cp0_status !== 32'h0040_0000 || bus3.new_pc !== 32'h0) begin errors++; $display("FAIL rstflush_regs got %h/%h exp 00400000/0", bus3.cp0_status, bus3.new_pc); end
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus3.new_pc_valid || bus3.stall_req) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstflush_noredirect got activity exp none"); end
  endtask

  initial begin
    test_reset();
    test_mtc0_mfc0();
    test_syscall();
    test_adel_dslot();
    test_eret();
    test_back_to_back();
    test_int_code();
    test_timer();
    test_reset_mid_flush();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
